data_bus_arbiter: RTL and testbench



---
 rtl/data_bus_arbiter_pkg.sv | 16 +
 rtl/data_bus_arbiter_rr2.sv | 24 ++
 rtl/data_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_data_bus_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the Gumnut data-bus arbiter and its round-robin picker.
// State codes double as the one-hot grant vector presented on gnt_o.
package data_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int TIMEOUT_W = 4;

endpackage

// File: rtl/data_bus_arbiter_rr2.sv
// Two-way round-robin grant picker: on a tie the master that was not served last wins.
// Purely combinational so it can be shared with the instruction-side bus.
module arb_rr2
    import data_bus_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       winner_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        valid_o  = |req_i;
        winner_o = M0;
        unique case (req_i)
            2'b01:   winner_o = M0;
            2'b10:   winner_o = M1;
            2'b11:   winner_o = (last_i == M1) ? M0 : M1;
            default: winner_o = M0;
        endcase
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin Wishbone-style arbiter in front of the Gumnut data memory.
// Define ARB_TIMEOUT_EN to abort a granted cycle that sees no ack for TIMEOUT cycles.
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int          AW      = 8,
    parameter int          DW      = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       rr_valid, rr_winner;
    logic       timeout_hit;

    arb_rr2 u_rr (
        .req_i    ({m1_cyc_i, m0_cyc_i}),
        .last_i   (last_q),
        .valid_o  (rr_valid),
        .winner_o (rr_winner)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= M1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: if (rr_valid) state_d = (rr_winner == M1) ? GNT1 : GNT0;
            GNT0: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                    last_d  = M0;
                end else if (!m0_cyc_i) begin
                    last_d  = M0;
                    state_d = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                    last_d  = M1;
                end else if (!m1_cyc_i) begin
                    last_d  = M1;
                    state_d = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave side follows the granted master combinationally so memory ack timing is preserved.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        unique case (state_q)
            GNT0: begin
                s_cyc_o  = m0_cyc_i & ~timeout_hit;
                s_stb_o  = m0_stb_i & ~timeout_hit;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i & m0_cyc_i & m0_stb_i & ~timeout_hit;
                m0_err_o = timeout_hit;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i & ~timeout_hit;
                s_stb_o  = m1_stb_i & ~timeout_hit;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i & m1_cyc_i & m1_stb_i & ~timeout_hit;
                m1_err_o = timeout_hit;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign gnt_o    = state_q;

`ifdef ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 gnt_stb;

    assign gnt_stb     = ((state_q == GNT0) & m0_stb_i) | ((state_q == GNT1) & m1_stb_i);
    assign timeout_hit = (state_q != IDLE) && (cnt_q == TIMEOUT_W'(TIMEOUT));

    always_comb begin
        if (!gnt_stb || s_ack_i || timeout_hit) cnt_d = '0;
        else                                    cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: a slave model plus a scoreboard of expected beats.
// Build with ARB_TIMEOUT_EN defined to exercise the abort path.
module tb_data_bus_arbiter;

    localparam logic [7:0] RD_KEY = 8'h1C;  // slave read data = address ^ RD_KEY

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [7:0] m0_adr = 0, m0_dat = 0;
    logic       m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [7:0] m1_adr = 0, m1_dat = 0;
    logic [7:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic       s_cyc_o, s_stb_o, s_we_o, s_ack_i;
    logic [1:0] gnt_o;

    logic force_ack   = 1'b0;
    logic slave_rd_en = 1'b1;
    logic rd_ack_q;

    typedef struct {
        int         m;
        bit         we;
        logic [7:0] adr;
        logic [7:0] dat;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_bus_arbiter #(.AW(8), .DW(8), .TIMEOUT(15)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    // Gumnut-like slave: writes ack in the same cycle, reads one cycle after stb.
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) rd_ack_q <= 1'b0;
        else         rd_ack_q <= s_cyc_o & s_stb_o & ~s_we_o & ~rd_ack_q;
    end
    assign s_ack_i = force_ack | (s_cyc_o & s_stb_o & (s_we_o | (rd_ack_q & slave_rd_en)));
    assign s_dat_i = s_adr_o ^ RD_KEY;

    // Scoreboard consumer: every forwarded ack must match the oldest expected beat.
    always @(negedge clk) begin : monitor
        exp_t       e;
        int         am;
        logic [7:0] got;
        if (rst_ni && (m0_ack_o || m1_ack_o)) begin
            total++;
            if (m0_ack_o && m1_ack_o) begin
                bad++;
                $display("FAIL dual_ack: m0_ack=1 m1_ack=1, required one at most");
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack: m0_ack=%b m1_ack=%b, required none", m0_ack_o, m1_ack_o);
            end else begin
                e   = sb.pop_front();
                am  = m1_ack_o ? 1 : 0;
                got = e.we ? s_dat_o : (am == 1 ? m1_dat_o : m0_dat_o);
                if (am != e.m || s_adr_o !== e.adr || got !== e.dat) begin
                    bad++;
                    $display("FAIL sb_beat: m=%0d adr=%h dat=%h, required m=%0d adr=%h dat=%h",
                             am, s_adr_o, got, e.m, e.adr, e.dat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input bit cyc, input bit stb, input bit we,
                         input logic [7:0] adr, input logic [7:0] dat);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat = dat;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat = dat;
        end
    endtask

    task automatic push(input int m, input bit we, input logic [7:0] adr, input logic [7:0] dat);
        exp_t e;
        e.m   = m;
        e.we  = we;
        e.adr = adr;
        e.dat = we ? dat : (adr ^ RD_KEY);
        sb.push_back(e);
    endtask

    // Returns the number of negedges until master m sees ack, or -1 if the budget expires.
    task automatic wait_ack(input int m, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if ((m == 0 && m0_ack_o) || (m == 1 && m1_ack_o)) return;
        end
        n = -1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        total++;
        do begin
            @(negedge clk);
            n++;
        end while (gnt_o !== 2'b00 && n < 8);
        if (gnt_o !== 2'b00) begin
            bad++;
            $display("FAIL idle_timeout: gnt=%b, required 00 within 8 cycles", gnt_o);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== '0) begin
            bad++;
            $display("FAIL reset_hold: gnt=%b s_cyc=%b s_stb=%b acks=%b%b errs=%b%b, required all 0",
                     gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o);
        end
        rst_ni = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: gnt=%b s_cyc=%b, required 00/0", gnt_o, s_cyc_o);
        end
    endtask

    task automatic test_single_write();
        int n;
        tick();
        drive(0, 1, 1, 1, 8'h10, 8'hA5);
        push(0, 1, 8'h10, 8'hA5);
        @(negedge clk);
        total++;
        if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin
            bad++;
            $display("FAIL wr_req_cycle: gnt=%b s_cyc=%b, required 00/0", gnt_o, s_cyc_o);
        end
        wait_ack(0, 4, n);
        total++;
        if (n != 1 || gnt_o !== 2'b01 || s_adr_o !== 8'h10 || s_dat_o !== 8'hA5 || s_we_o !== 1'b1 || m1_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL wr_grant: n=%0d gnt=%b adr=%h dat=%h we=%b m1_ack=%b, required 1/01/10/a5/1/0",
                     n, gnt_o, s_adr_o, s_dat_o, s_we_o, m1_ack_o);
        end
        tick();
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        wait_idle();
    endtask

    task automatic test_read_latency();
        int n;
        tick();
        drive(0, 1, 1, 0, 8'h20, 8'h00);
        push(0, 0, 8'h20, 8'h00);
        wait_ack(0, 8, n);
        total++;
        if (n != 3 || m0_dat_o !== 8'h3C) begin
            bad++;
            $display("FAIL rd_latency: cycles=%0d dat=%h, required 3/3c", n, m0_dat_o);
        end
        tick();
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        wait_idle();
    endtask

    task automatic test_idle_ack();
        int n;
        tick();
        force_ack = 1'b1;
        drive(0, 1, 1, 1, 8'h30, 8'h11);
        @(negedge clk);
        total++;
        if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_ack: m0_ack=%b m1_ack=%b, required 0/0", m0_ack_o, m1_ack_o);
        end
        force_ack = 1'b0;
        push(0, 1, 8'h30, 8'h11);
        wait_ack(0, 4, n);
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL idle_ack_then_grant: n=%0d, required 1", n);
        end
        tick();
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        wait_idle();
    endtask

    task automatic test_tie();
        int n;
        pulse_reset();
        tick();
        drive(0, 1, 1, 1, 8'h40, 8'h01);
        drive(1, 1, 1, 1, 8'h41, 8'h02);
        push(0, 1, 8'h40, 8'h01);
        wait_ack(0, 4, n);
        total++;
        if (n != 2 || gnt_o !== 2'b01 || m1_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL tie_first: n=%0d gnt=%b m1_ack=%b, required 2/01/0", n, gnt_o, m1_ack_o);
        end
        tick();
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        push(1, 1, 8'h41, 8'h02);
        wait_ack(1, 4, n);
        total++;
        if (n != 2 || gnt_o !== 2'b10) begin
            bad++;
            $display("FAIL tie_handover: n=%0d gnt=%b, required 2/10", n, gnt_o);
        end
        tick();
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        wait_idle();
        tick();
        drive(0, 1, 1, 1, 8'h42, 8'h03);
        drive(1, 1, 1, 1, 8'h43, 8'h04);
        push(0, 1, 8'h42, 8'h03);
        wait_ack(0, 4, n);
        total++;
        if (n != 2 || gnt_o !== 2'b01) begin
            bad++;
            $display("FAIL tie_second: n=%0d gnt=%b, required 2/01", n, gnt_o);
        end
        tick();
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        wait_idle();
    endtask

    task automatic test_block_hold();
        int n;
        tick();
        drive(1, 1, 1, 1, 8'h50, 8'h60);
        drive(0, 1, 1, 1, 8'h70, 8'h77);
        push(1, 1, 8'h50, 8'h60);
        wait_ack(1, 4, n);
        total++;
        if (n != 2 || gnt_o !== 2'b10) begin
            bad++;
            $display("FAIL blk_first: n=%0d gnt=%b, required 2/10", n, gnt_o);
        end
        for (int b = 1; b < 4; b++) begin
            tick();
            m1_stb = 1'b0;
            @(negedge clk);
            total++;
            if (gnt_o !== 2'b10 || s_stb_o !== 1'b0) begin
                bad++;
                $display("FAIL blk_gap%0d: gnt=%b s_stb=%b, required 10/0", b, gnt_o, s_stb_o);
            end
            tick();
            drive(1, 1, 1, 1, 8'h50 + 8'(b), 8'h60 + 8'(b));
            push(1, 1, 8'h50 + 8'(b), 8'h60 + 8'(b));
            wait_ack(1, 4, n);
            total++;
            if (n != 1 || gnt_o !== 2'b10) begin
                bad++;
                $display("FAIL blk_beat%0d: n=%0d gnt=%b, required 1/10", b, n, gnt_o);
            end
        end
        tick();
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        push(0, 1, 8'h70, 8'h77);
        wait_ack(0, 4, n);
        total++;
        if (n != 2 || gnt_o !== 2'b01) begin
            bad++;
            $display("FAIL blk_handover: n=%0d gnt=%b, required 2/01", n, gnt_o);
        end
        tick();
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        wait_idle();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        slave_rd_en = 1'b0;
        tick();
        drive(0, 1, 1, 0, 8'h21, 8'h00);
        @(negedge clk);
        n = 1;
        tick();
        drive(1, 1, 1, 1, 8'h80, 8'h88);
        push(1, 1, 8'h80, 8'h88);
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (m0_err_o) break;
        end
        total++;
        if (n != 17 || m0_err_o !== 1'b1 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m1_err_o !== 1'b0) begin
            bad++;
            $display("FAIL to_pulse: at=%0d err=%b s_cyc=%b s_stb=%b, required 17/1/0/0", n, m0_err_o, s_cyc_o, s_stb_o);
        end
        tick();
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        total++;
        if (m0_err_o !== 1'b0 || gnt_o !== 2'b00) begin
            bad++;
            $display("FAIL to_idle: err=%b gnt=%b, required 0/00", m0_err_o, gnt_o);
        end
        wait_ack(1, 4, n);
        total++;
        if (n != 1 || gnt_o !== 2'b10) begin
            bad++;
            $display("FAIL to_next_grant: n=%0d gnt=%b, required 1/10", n, gnt_o);
        end
        slave_rd_en = 1'b1;
        tick();
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        wait_idle();
    endtask
`else
    task automatic test_no_timeout();
        int n;
        int viol;
        viol = 0;
        slave_rd_en = 1'b0;
        tick();
        drive(0, 1, 1, 0, 8'h21, 8'h00);
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (m0_err_o !== 1'b0 || m1_err_o !== 1'b0 || gnt_o !== 2'b01) viol++;
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL no_timeout: violations=%0d, required 0", viol);
        end
        push(0, 0, 8'h21, 8'h00);
        slave_rd_en = 1'b1;
        wait_ack(0, 4, n);
        total++;
        if (n < 1) begin
            bad++;
            $display("FAIL no_timeout_ack: n=%0d, required ack within 4", n);
        end
        tick();
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        wait_idle();
    endtask
`endif

    task automatic test_reset_mid_read();
        tick();
        drive(0, 1, 1, 0, 8'h22, 8'h00);
        push(0, 0, 8'h22, 8'h00);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (gnt_o !== 2'b01 || m0_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_pre: gnt=%b ack=%b, required 01/0", gnt_o, m0_ack_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if (s_cyc_o !== 1'b0 || gnt_o !== 2'b00 || m0_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_async: s_cyc=%b gnt=%b ack=%b, required 0/00/0", s_cyc_o, gnt_o, m0_ack_o);
        end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        total++;
        if (m0_ack_o !== 1'b0 || s_cyc_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_hold: ack=%b s_cyc=%b, required 0/0", m0_ack_o, s_cyc_o);
        end
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        rst_ni = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (gnt_o !== 2'b00 || m0_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_after: gnt=%b ack=%b, required 00/0", gnt_o, m0_ack_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_latency();
        test_idle_ack();
        test_tie();
        test_block_hold();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_read();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: pending=%0d, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
